// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request at a time, captured word held
// for the decoder under valid/ready, with branch redirect and sticky errors.
module instr_fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [PC_W-1:0] pc_out,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            fetch_err,
  output logic [1:0]      err_code,
  output logic [2:0]      fsm_state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [2:0]      state;
  logic [PC_W-1:0] pc;
  logic [31:0]     instr_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]      err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      instr_q  <= '0;
      wait_cnt <= '0;
      err_q    <= 2'b00;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_gnt) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          // Data on the last allowed cycle is still accepted.
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            state   <= S_VALID;
          end else if (wait_cnt == CNT_LAST) begin
            state <= S_ERR;
            err_q <= 2'b01;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            if (branch_taken && (branch_target[1:0] != 2'b00)) begin
              state <= S_ERR;
              err_q <= 2'b10;
            end else begin
              pc    <= branch_taken ? branch_target : pc + PC_W'(4);
              state <= S_REQ;
            end
          end
        end
        S_ERR:   state <= S_ERR;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == S_VALID);
  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign funct3      = instr_q[14:12];
  assign funct7      = instr_q[31:25];
  assign pc_out      = pc;
  assign fetch_err   = (state == S_ERR);
  assign err_code    = err_q;
  assign fsm_state   = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a scripted/random imem responder and decoder,
// checked against a PC/instruction reference model.
module tb_instr_fetch_unit;
  localparam int PC_W = 64;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int TIMEOUT = 16;

  logic            clk, rst_n;
  logic            imem_req, imem_gnt, imem_rvalid;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata, instr;
  logic            instr_valid, instr_ready;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [PC_W-1:0] pc_out, branch_target;
  logic            branch_taken, fetch_err;
  logic [1:0]      err_code;
  logic [2:0]      fsm_state;

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_pc;
  logic [31:0]     exp_q[$];

  instr_fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .pc_out(pc_out),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_err(fetch_err), .err_code(err_code), .fsm_state(fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  // Driver tasks: all called and returning at a negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    exp_q.delete();
  endtask

  task automatic fetch_one(input logic [31:0] word, input int gd, input int rd,
                           output logic [PC_W-1:0] addr, output bit ok);
    int n;
    ok = 1'b0; addr = '0; n = 0;
    while (!imem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) return;
    addr = imem_addr;
    repeat (gd) @(negedge clk);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (rd) @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_rvalid = 1'b0; imem_rdata = $urandom;
    ok = instr_valid;
  endtask

  task automatic handshake(input bit bt, input logic [PC_W-1:0] tgt);
    instr_ready = 1'b1; branch_taken = bt; branch_target = tgt;
    @(negedge clk);
    instr_ready = 1'b0;
    branch_taken = 1'($urandom);
    branch_target = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEADBEEF;
    instr_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL reset_pc_out: got %h want %h", pc_out, RESET_PC); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    checks++; if ({fetch_err, err_code} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", {fetch_err, err_code}); end
    imem_rvalid = 1'b0;
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req_timing: got %b want 1", imem_req); end
  endtask

  task automatic test_first_fetch();
    logic [PC_W-1:0] a; bit ok;
    fetch_one(32'h00500093, 0, 0, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL first_valid: got 0 want 1"); end
    checks++; if (a !== 64'h0) begin errors++; $display("FAIL first_addr: got %h want 0", a); end
    checks++; if (opcode !== 7'h13) begin errors++; $display("FAIL first_opcode: got %h want 13", opcode); end
    checks++; if (funct3 !== 3'd0) begin errors++; $display("FAIL first_funct3: got %h want 0", funct3); end
    checks++; if (pc_out !== 64'h0) begin errors++; $display("FAIL first_pc_out: got %h want 0", pc_out); end
    checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL first_instr: got %h want 00500093", instr); end
    handshake(1'b0, '0);
  endtask

  task automatic test_sequential();
    logic [PC_W-1:0] a; bit ok; logic [31:0] w;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      fetch_one(w, 0, 0, a, ok);
      checks++; if (a !== exp_pc || !ok) begin errors++; $display("FAIL seq_addr[%0d]: got %h ok=%b want %h", i, a, ok, exp_pc); end
      checks++; if (instr !== w) begin errors++; $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, w); end
      handshake(1'b0, '0);
      exp_pc = exp_pc + 4;
    end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] a; bit ok;
    fetch_one(32'h40B50533, 1, 2, a, ok);
    checks++; if (a !== exp_pc || !ok) begin errors++; $display("FAIL bp_addr: got %h ok=%b want %h", a, ok, exp_pc); end
    for (int i = 0; i < 5; i++) begin
      branch_taken = 1'b1; branch_target = 64'h3;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h40B50533 || funct7 !== 7'h20 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b instr=%h funct7=%h req=%b want 1 40b50533 20 0",
                 i, instr_valid, instr, funct7, imem_req);
      end
    end
    handshake(1'b0, '0);
    exp_pc = exp_pc + 4;
  endtask

  task automatic test_branch();
    logic [PC_W-1:0] a; bit ok;
    logic [PC_W-1:0] tgts[3];
    tgts[0] = 64'hFFFF_FFFF_FFFF_FFFC; tgts[1] = 64'h0; tgts[2] = 64'h100;
    fetch_one($urandom, 0, 0, a, ok);
    handshake(1'b1, tgts[0]);
    exp_pc = tgts[0];
    fetch_one($urandom, 0, 1, a, ok);
    checks++; if (a !== exp_pc || !ok) begin errors++; $display("FAIL br_far: got %h want %h", a, exp_pc); end
    handshake(1'b0, '0);
    exp_pc = exp_pc + 4;
    fetch_one($urandom, 0, 0, a, ok);
    checks++; if (a !== tgts[1] || !ok) begin errors++; $display("FAIL pc_wrap: got %h want %h", a, tgts[1]); end
    handshake(1'b1, tgts[2]);
    fetch_one($urandom, 0, 0, a, ok);
    checks++; if (a !== tgts[2] || !ok) begin errors++; $display("FAIL br_taken: got %h want 100", a); end
    handshake(1'b1, 64'h102);
    checks++; if (fetch_err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL misaligned: got err=%b code=%b want 1 10", fetch_err, err_code); end
    for (int i = 0; i < 5; i++) begin
      imem_gnt = 1'b1; imem_rvalid = 1'b1;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1 || pc_out !== 64'h100) begin
        errors++;
        $display("FAIL err_absorb[%0d]: got req=%b valid=%b err=%b pc=%h want 0 0 1 100",
                 i, imem_req, instr_valid, fetch_err, pc_out);
      end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
  endtask

  task automatic test_timeout();
    logic [PC_W-1:0] a; bit ok; logic [31:0] w; int n;
    apply_reset();
    n = 0;
    while (!imem_req && n < 10) begin @(negedge clk); n++; end
    checks++; if (!imem_req) begin errors++; $display("FAIL to_req: got 0 want 1"); end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TIMEOUT - 1) begin
        checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", fetch_err); end
      end
    end
    checks++; if (fetch_err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL timeout: got err=%b code=%b want 1 01", fetch_err, err_code); end
    checks++; if (pc_out !== RESET_PC) begin errors++; $display("FAIL to_pc: got %h want %h", pc_out, RESET_PC); end
    apply_reset();
    w = $urandom;
    fetch_one(w, 0, TIMEOUT - 1, a, ok);
    checks++; if (!ok || fetch_err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL to_last_cycle: got ok=%b err=%b code=%b want 1 0 00", ok, fetch_err, err_code); end
    checks++; if (instr !== w) begin errors++; $display("FAIL to_last_data: got %h want %h", instr, w); end
    handshake(1'b0, '0);
    exp_pc = exp_pc + 4;
  endtask

  task automatic test_random();
    logic [PC_W-1:0] a, tgt; bit ok, bt; logic [31:0] w, e;
    for (int i = 0; i < 25; i++) begin
      w = $urandom;
      exp_q.push_back(w);
      fetch_one(w, $urandom_range(0, 3), $urandom_range(0, 8), a, ok);
      checks++; if (a !== exp_pc || !ok) begin errors++; $display("FAIL rnd_addr[%0d]: got %h ok=%b want %h", i, a, ok, exp_pc); end
      e = exp_q.pop_front();
      checks++;
      if (instr !== e || opcode !== 7'(e % 128) || funct3 !== 3'((e >> 12) % 8) ||
          funct7 !== 7'(e >> 25) || pc_out !== exp_pc) begin
        errors++;
        $display("FAIL rnd_instr[%0d]: got %h/%h/%h/%h pc %h want %h pc %h",
                 i, instr, opcode, funct3, funct7, pc_out, e, exp_pc);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bt = ($urandom_range(0, 3) == 0);
      tgt = {$urandom, $urandom} & ~64'h3;
      handshake(bt, tgt);
      exp_pc = bt ? tgt : exp_pc + 4;
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [PC_W-1:0] a; bit ok; logic [31:0] w; int n;
    n = 0;
    while (!imem_req && n < 10) begin @(negedge clk); n++; end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== RESET_PC ||
        pc_out !== RESET_PC || fetch_err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL midwait_reset: got req=%b valid=%b instr=%h addr=%h err=%b want reset values",
               imem_req, instr_valid, instr, imem_addr, fetch_err);
    end
    imem_rvalid = 1'b1; imem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    checks++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rvalid_in_reset: got instr=%h valid=%b want 0 0", instr, instr_valid); end
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    @(negedge clk);
    imem_rvalid = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || instr_valid !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_req: got req=%b addr=%h valid=%b instr=%h want 1 %h 0 0",
               imem_req, imem_addr, instr_valid, instr, RESET_PC);
    end
    w = $urandom;
    fetch_one(w, 0, 0, a, ok);
    checks++; if (a !== RESET_PC || !ok || instr !== w) begin errors++; $display("FAIL post_reset_fetch: got %h %h want %h %h", a, instr, RESET_PC, w); end
    handshake(1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_backpressure();
    test_branch();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
